// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
//   Bundles the two requester ports (P0 = CPU load/store, P1 = UART debug/loader)
//   and the single-port data memory bus that the arbiter drives.
//   Modports:
//     slave  - the arbiter view: takes requests and mem_dout, drives grants,
//              read responses, cpu_stall and the mem_* command.
//     master - the environment view (requesters + memory), the mirror image.
//   Signals:
//     pN_req / pN_we[4] / pN_addr / pN_wdata   request from port N
//     pN_gnt / pN_rvalid / pN_rdata[32]        grant and read response to port N
//     cpu_stall                                P0 request not accepted this cycle
//     mem_en / mem_we[4] / mem_addr / mem_din  memory command
//     mem_dout[32]                             memory read data, one cycle after a read
interface dmem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  p0_req;
  logic [3:0]            p0_we;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [31:0]           p0_wdata;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic [31:0]           p0_rdata;
  logic                  cpu_stall;

  logic                  p1_req;
  logic [3:0]            p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [31:0]           p1_wdata;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [31:0]           p1_rdata;

  logic                  mem_en;
  logic [3:0]            mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_din;
  logic [31:0]           mem_dout;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, cpu_stall,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_en, mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, cpu_stall,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_en, mem_we, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-port synchronous-read data memory between the CPU port (P0)
//   and the debug/loader port (P1). At most one access is granted per cycle, in
//   the same cycle as the request. P0 has fixed priority; a saturating starvation
//   counter forces a P1 grant after STARVE_LIMIT consecutive denials. Read data is
//   returned one cycle after the grant to the port that won it.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous reset, active-high
//     bus  - dmem_port_arbiter_if.slave (requests, responses, memory command)
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  dmem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_P0 = 2'd1,
    OWN_P1 = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       force_p1;
  logic       gnt0, gnt1;
  logic       rd_gnt;
  logic       rd_vld_p1;
  logic       rsel_p1;
  logic       rvalid0, rvalid1;
  logic [31:0] hold0_p1, hold1_p1;

  // Arbitration and next owner, all combinational from requests and counter.
  always_comb begin
    force_p1   = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    rd_gnt     = 1'b0;
    state_nxt  = IDLE;
    starve_nxt = 4'd0;

    force_p1 = bus.p1_req && (starve_cnt == LIMIT);
    gnt1     = force_p1 || (bus.p1_req && !bus.p0_req);
    gnt0     = bus.p0_req && !gnt1;

    if (gnt1) begin
      state_nxt = OWN_P1;
      rd_gnt    = (bus.p1_we == 4'h0);
    end else if (gnt0) begin
      state_nxt = OWN_P0;
      rd_gnt    = (bus.p0_we == 4'h0);
    end

    // Counts consecutive denied P1 cycles; saturates so it can never pass the limit.
    if (bus.p1_req && !gnt1) begin
      starve_nxt = (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;
    end
  end

  // Stage p1: registered owner, read-pending flag and starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      rd_vld_p1  <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      rd_vld_p1  <= rd_gnt;
    end
  end

  // The last owner doubles as the read-return select; IDLE selects P0.
  assign rsel_p1 = (state == OWN_P1);
  assign rvalid0 = rd_vld_p1 && !rsel_p1;
  assign rvalid1 = rd_vld_p1 &&  rsel_p1;

  // Each port keeps showing its last returned word while the other port reads.
  always_ff @(posedge clk) begin
    if (rvalid0) hold0_p1 <= bus.mem_dout;
    if (rvalid1) hold1_p1 <= bus.mem_dout;
  end

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.cpu_stall = bus.p0_req && !gnt0;

  assign bus.mem_en   = gnt0 || gnt1;
  assign bus.mem_we   = gnt1 ? bus.p1_we : (gnt0 ? bus.p0_we : 4'h0);
  assign bus.mem_addr = gnt1 ? bus.p1_addr  : bus.p0_addr;
  assign bus.mem_din  = gnt1 ? bus.p1_wdata : bus.p0_wdata;

  assign bus.p0_rvalid = rvalid0;
  assign bus.p1_rvalid = rvalid1;
  assign bus.p0_rdata  = rvalid0 ? bus.mem_dout : hold0_p1;
  assign bus.p1_rdata  = rvalid1 ? bus.mem_dout : hold1_p1;

endmodule
